// File: rtl/barramento_pkg.sv
// Shared constants for the barramento six-port data bus.
package barramento_pkg;

    localparam int N_SOURCES       = 4;
    localparam int N_SINKS         = 2;
    localparam int CTRL_RD_BIT     = 0;
    localparam int CTRL_WR_BIT     = 1;
    localparam int LARGURA_DEFAULT = 16;

endpackage

// File: rtl/barramento_arbiter.sv
// Fixed-priority arbiter for the bus sources: the lowest-index write request wins.
module barramento_arbiter
    import barramento_pkg::*;
(
    input  logic [N_SOURCES-1:0] req,
    output logic [N_SOURCES-1:0] grant,
    output logic                 valid,
    output logic                 multi
);

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;
    // Any request left over after removing the winner means two or more writers.
    assign multi = |(req & ~grant);

endmodule

// File: rtl/barramento.sv
// Six-port shared bus: sources 0-3 drive, sinks 4-5 capture on a one-cycle registered path.
// Optional collision flag when BARRAMENTO_COLLISION_EN is defined.
// There is no handshake: ctrl words are level-sampled at every rising clk edge;
// a source requests with ctrl[1], a sink captures with ctrl[0].
module barramento
    import barramento_pkg::*;
#(
    parameter int Largura_barramento = LARGURA_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [Largura_barramento-1:0] io_0,
    input  logic [Largura_barramento-1:0] io_1,
    input  logic [Largura_barramento-1:0] io_2,
    input  logic [Largura_barramento-1:0] io_3,
    output logic [Largura_barramento-1:0] io_4,
    output logic [Largura_barramento-1:0] io_5,
    input  logic [1:0]                    ctrl_0,
    input  logic [1:0]                    ctrl_1,
    input  logic [1:0]                    ctrl_2,
    input  logic [1:0]                    ctrl_3,
    input  logic [1:0]                    ctrl_4,
    input  logic [1:0]                    ctrl_5
`ifdef BARRAMENTO_COLLISION_EN
    ,
    output logic                          collision
`endif
);

    logic [Largura_barramento-1:0] src [N_SOURCES];
    logic [N_SOURCES-1:0]          req;
    logic [N_SOURCES-1:0]          grant;
    logic                          bus_valid;
    logic                          multi;
    logic [Largura_barramento-1:0] bus_data;
    logic                          unused_ctrl;

    assign src[0] = io_0;
    assign src[1] = io_1;
    assign src[2] = io_2;
    assign src[3] = io_3;

    assign req = {ctrl_3[CTRL_WR_BIT], ctrl_2[CTRL_WR_BIT],
                  ctrl_1[CTRL_WR_BIT], ctrl_0[CTRL_WR_BIT]};

    // Direction bits that do not match a port's class are ignored.
`ifdef BARRAMENTO_COLLISION_EN
    assign unused_ctrl = ^{ctrl_0[CTRL_RD_BIT], ctrl_1[CTRL_RD_BIT], ctrl_2[CTRL_RD_BIT],
                           ctrl_3[CTRL_RD_BIT], ctrl_4[CTRL_WR_BIT], ctrl_5[CTRL_WR_BIT]};
`else
    assign unused_ctrl = ^{ctrl_0[CTRL_RD_BIT], ctrl_1[CTRL_RD_BIT], ctrl_2[CTRL_RD_BIT],
                           ctrl_3[CTRL_RD_BIT], ctrl_4[CTRL_WR_BIT], ctrl_5[CTRL_WR_BIT],
                           multi};
`endif

    barramento_arbiter u_arbiter (
        .req   (req),
        .grant (grant),
        .valid (bus_valid),
        .multi (multi)
    );

    // Grant is one-hot, so OR-ing the gated sources selects exactly the winner.
    always_comb begin
        bus_data = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (grant[i]) begin
                bus_data = bus_data | src[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_4 <= '0;
            io_5 <= '0;
        end else begin
            if (bus_valid && ctrl_4[CTRL_RD_BIT]) begin
                io_4 <= bus_data;
            end
            if (bus_valid && ctrl_5[CTRL_RD_BIT]) begin
                io_5 <= bus_data;
            end
        end
    end

`ifdef BARRAMENTO_COLLISION_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
        end else begin
            collision <= multi;
        end
    end
`endif

endmodule

// File: tb/tb_barramento.sv
// Directed self-checking bench for barramento (collision checks only with BARRAMENTO_COLLISION_EN).
module tb_barramento;

    logic        clk;
    logic        rst_n;
    logic [15:0] io_0, io_1, io_2, io_3, io_4, io_5;
    logic [1:0]  ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5;
`ifdef BARRAMENTO_COLLISION_EN
    logic        collision;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    barramento dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_0   (io_0),
        .io_1   (io_1),
        .io_2   (io_2),
        .io_3   (io_3),
        .io_4   (io_4),
        .io_5   (io_5),
        .ctrl_0 (ctrl_0),
        .ctrl_1 (ctrl_1),
        .ctrl_2 (ctrl_2),
        .ctrl_3 (ctrl_3),
        .ctrl_4 (ctrl_4),
        .ctrl_5 (ctrl_5)
`ifdef BARRAMENTO_COLLISION_EN
        ,
        .collision (collision)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        ctrl_0 = 2'b00; ctrl_1 = 2'b00; ctrl_2 = 2'b00;
        ctrl_3 = 2'b00; ctrl_4 = 2'b00; ctrl_5 = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_ctrl();
        io_0 = 16'h0000; io_1 = 16'h0000; io_2 = 16'h0000; io_3 = 16'h0000;
        repeat (3) tick();
        n_checks++;
        if (io_4 !== 16'h0000) begin
            n_fails++; $display("FAIL reset_io4: got %h expected 0000", io_4);
        end
        n_checks++;
        if (io_5 !== 16'h0000) begin
            n_fails++; $display("FAIL reset_io5: got %h expected 0000", io_5);
        end
`ifdef BARRAMENTO_COLLISION_EN
        n_checks++;
        if (collision !== 1'b0) begin
            n_fails++; $display("FAIL reset_collision: got %b expected 0", collision);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        clear_ctrl();
        io_0 = 16'h0002; ctrl_0 = 2'b10; ctrl_4 = 2'b01;
        tick();
        n_checks++;
        if (io_4 !== 16'h0002) begin
            n_fails++; $display("FAIL single_io4: got %h expected 0002", io_4);
        end
        n_checks++;
        if (io_5 !== 16'h0000) begin
            n_fails++; $display("FAIL single_io5_hold: got %h expected 0000", io_5);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp;
        for (int x = 0; x < 4; x++) begin
            clear_ctrl();
            exp  = 16'(x + 10);
            io_0 = (x == 0) ? exp : 16'hDEAD;
            io_1 = (x == 1) ? exp : 16'hBEEF;
            io_2 = (x == 2) ? exp : 16'hCAFE;
            io_3 = (x == 3) ? exp : 16'hF00D;
            case (x)
                0: ctrl_0 = 2'b10;
                1: ctrl_1 = 2'b10;
                2: ctrl_2 = 2'b10;
                default: ctrl_3 = 2'b10;
            endcase
            ctrl_4 = 2'b01; ctrl_5 = 2'b01;
            tick();
            n_checks++;
            if (io_4 !== exp) begin
                n_fails++; $display("FAIL sweep_io4 src=%0d: got %h expected %h", x, io_4, exp);
            end
            n_checks++;
            if (io_5 !== exp) begin
                n_fails++; $display("FAIL sweep_io5 src=%0d: got %h expected %h", x, io_5, exp);
            end
`ifdef BARRAMENTO_COLLISION_EN
            n_checks++;
            if (collision !== 1'b0) begin
                n_fails++; $display("FAIL sweep_collision src=%0d: got %b expected 0", x, collision);
            end
`endif
        end
    endtask

    task automatic test_priority();
        // io_4 and io_5 both hold 000d from the last sweep step.
        clear_ctrl();
        io_1 = 16'h1111; io_3 = 16'h3333;
        ctrl_1 = 2'b10; ctrl_3 = 2'b10; ctrl_5 = 2'b01;
        tick();
        n_checks++;
        if (io_5 !== 16'h1111) begin
            n_fails++; $display("FAIL priority_io5: got %h expected 1111", io_5);
        end
        n_checks++;
        if (io_4 !== 16'h000D) begin
            n_fails++; $display("FAIL priority_io4_hold: got %h expected 000d", io_4);
        end
`ifdef BARRAMENTO_COLLISION_EN
        n_checks++;
        if (collision !== 1'b1) begin
            n_fails++; $display("FAIL priority_collision: got %b expected 1", collision);
        end
`endif
        // ctrl=11 everywhere: source acts as writer, sink acts as reader.
        clear_ctrl();
        io_2 = 16'h2222; ctrl_2 = 2'b11; ctrl_4 = 2'b11; ctrl_5 = 2'b10;
        tick();
        n_checks++;
        if (io_4 !== 16'h2222) begin
            n_fails++; $display("FAIL ctrl11_io4: got %h expected 2222", io_4);
        end
        n_checks++;
        if (io_5 !== 16'h1111) begin
            n_fails++; $display("FAIL ctrl11_io5_hold: got %h expected 1111", io_5);
        end
`ifdef BARRAMENTO_COLLISION_EN
        n_checks++;
        if (collision !== 1'b0) begin
            n_fails++; $display("FAIL ctrl11_collision: got %b expected 0", collision);
        end
`endif
    endtask

    task automatic test_idle();
        clear_ctrl();
        io_0 = 16'h0005; ctrl_0 = 2'b10; ctrl_4 = 2'b01;
        tick();
        n_checks++;
        if (io_4 !== 16'h0005) begin
            n_fails++; $display("FAIL idle_load_io4: got %h expected 0005", io_4);
        end
        clear_ctrl();
        io_0 = 16'h0009;
        for (int i = 0; i < 3; i++) begin
            // Last edge has a reader but no writer: still no update.
            if (i == 2) ctrl_4 = 2'b01;
            tick();
            n_checks++;
            if (io_4 !== 16'h0005) begin
                n_fails++; $display("FAIL idle_hold_io4 edge=%0d: got %h expected 0005", i, io_4);
            end
`ifdef BARRAMENTO_COLLISION_EN
            n_checks++;
            if (collision !== 1'b0) begin
                n_fails++; $display("FAIL idle_collision edge=%0d: got %b expected 0", i, collision);
            end
`endif
        end
    endtask

    task automatic test_late_change();
        clear_ctrl();
        io_0 = 16'h0002; ctrl_0 = 2'b10; ctrl_4 = 2'b01;
        tick();
        io_0 = 16'h0007;
        #2;
        n_checks++;
        if (io_4 !== 16'h0002) begin
            n_fails++; $display("FAIL late_before_edge_io4: got %h expected 0002", io_4);
        end
        tick();
        n_checks++;
        if (io_4 !== 16'h0007) begin
            n_fails++; $display("FAIL late_after_edge_io4: got %h expected 0007", io_4);
        end
    endtask

    task automatic test_reset_mid();
        clear_ctrl();
        io_0 = 16'h00AA; ctrl_0 = 2'b10; ctrl_4 = 2'b01; ctrl_5 = 2'b01;
        tick();
        n_checks++;
        if (io_4 !== 16'h00AA) begin
            n_fails++; $display("FAIL rstmid_load_io4: got %h expected 00aa", io_4);
        end
        // Asynchronous assertion between edges, transfer still requested.
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (io_4 !== 16'h0000) begin
            n_fails++; $display("FAIL rstmid_io4: got %h expected 0000", io_4);
        end
        n_checks++;
        if (io_5 !== 16'h0000) begin
            n_fails++; $display("FAIL rstmid_io5: got %h expected 0000", io_5);
        end
`ifdef BARRAMENTO_COLLISION_EN
        n_checks++;
        if (collision !== 1'b0) begin
            n_fails++; $display("FAIL rstmid_collision: got %b expected 0", collision);
        end
`endif
        tick();
        n_checks++;
        if (io_4 !== 16'h0000) begin
            n_fails++; $display("FAIL rstmid_held_io4: got %h expected 0000", io_4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        io_0 = 16'h0BCD;
        tick();
        n_checks++;
        if (io_4 !== 16'h0BCD) begin
            n_fails++; $display("FAIL post_reset_io4: got %h expected 0bcd", io_4);
        end
        n_checks++;
        if (io_5 !== 16'h0BCD) begin
            n_fails++; $display("FAIL post_reset_io5: got %h expected 0bcd", io_5);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_priority();
        test_idle();
        test_late_change();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
